alu_mc: RTL
===========

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU with a valid/ready handshake and registered result and flags.
//  Executes the core op set in one cycle, and MUL as an iterative shift-add over W cycles.
//  Produces correct signed/unsigned branch flags. Sits between decode/regfile and writeback/PC logic.
// PARAMETERS
//  W    8  datapath width (>=4; power of 2 not required)
//  Ops  4  opcode width; opcode values come from package definitions::op_mne
// PORTS
//  Clk         in   1    clock, all state on rising edge
//  Reset_n     in   1    asynchronous, active-low reset
//  InValid     in   1    operands/opcode presented
//  InReady     out  1    ALU accepts; transfer when InValid&InReady at a rising edge
//  InputA      in   W    operand A
//  InputB      in   W    operand B; shift ops use B as the unsigned shift amount
//  OP          in   Ops  opcode (op_mne)
//  OutValid    out  1    result registers hold a valid result
//  OutReady    in   1    consumer takes result when OutValid&OutReady at a rising edge
//  Out         out  W    result (low half for MUL)
//  OutHi       out  W    MUL high half; 0 for every other op
//  Zero        out  1    Out==0 (MUL: {OutHi,Out}==0)
//  Negative    out  1    Out[W-1] (MUL: OutHi[W-1])
//  Carry       out  1    ADD carry-out; SUB/BGE/BNE/BEQ = no-borrow (A>=B unsigned); 0 otherwise
//  BranchFlag  out  1    BEQ: A==B; BNE: A!=B; BGE: signed A>=B (N^V==0); 0 for other ops
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; InReady=1; OutValid=0; Out, OutHi, and all flags = 0.
//   Any MUL in flight is discarded.
//  FSM IDLE/BUSY/DONE:
//   - IDLE: InReady=1. On accept of a 1-cycle op -> DONE, results registered on the same edge.
//     On accept of MUL -> BUSY, count=W-1, operands latched.
//   - BUSY: InReady=0, OutValid=0. One shift-add step per edge.
//     When count==0 -> DONE with {OutHi,Out}=A*B unsigned; else count-1.
//   - DONE: OutValid=1; Out/OutHi/flags held stable until consumed. InReady = OutReady.
//     On consume: with a simultaneous accept, -> DONE (1-cycle op, new result) or BUSY (MUL);
//     without an accept -> IDLE.
//  Latency: 1-cycle op accepted at edge N gives OutValid after edge N (throughput 1 per cycle
//   with OutReady=1). MUL accepted at edge N gives OutValid after edge N+W.
//  OutValid=1 with OutReady=0: stall indefinitely; nothing changes; InReady=0.
//  Ops:
//   - ADD: A+B mod 2^W.
//   - SUB/BGE/BNE/BEQ: A+~B+1.
//   - LSH/RSH: logical shift; B>=W -> 0.
//   - ASR: arithmetic right shift; B>=W -> all bits = A[W-1].
//   - MOV: B.
//   - XOR/AND/OR: bitwise.
//   - RXOR: {W-1 zeros, ^A[W-2:0]}.
//   - MUL: unsigned 2W-bit product.
//  Undefined opcode: 1-cycle, Out=0, OutHi=0, Zero=1, all other flags 0.
//  Flags are registered together with Out; never combinational from the inputs.
// STRUCTURE
//  Package definitions:
//   - op_mne extended: existing codes unchanged, MUL=4'hC, ASR=4'hD.
//   - typedef enum logic[1:0] alu_state_t {IDLE, BUSY, DONE}.
//   - localparam predicate is_branch(op).
//  Sub-module alu_mul_iter (Clk, Reset_n, start, A, B, busy, done, prod[2W-1:0]):
//   radix-2 shift-add multiplier, W iterations. Single-cycle datapath stays inline.
// TESTING
//  - Reset: Reset_n=0 mid-MUL (cycle 3 of 8) -> immediately OutValid=0, InReady=1, Out=0;
//    after release, ADD 2+3 -> Out=5.
//  - W=8 SUB 8'h05-8'h07 -> Out=8'hFE, Negative=1, Carry=0. BGE 8'h80 vs 8'h01 -> BranchFlag=0.
//    BGE 8'h01 vs 8'h80 -> BranchFlag=1.
//  - BEQ 8'h3C,8'h3C -> BranchFlag=1, Zero=1. BNE with the same operands -> BranchFlag=0.
//    BNE 8'h3C,8'h3D -> BranchFlag=1.
//  - MUL 8'hFF*8'hFF accepted at edge N -> OutValid after edge N+8, {OutHi,Out}=16'hFE01.
//    InReady=0 throughout BUSY.
//  - Shifts: LSH 8'h81 by 1 -> 8'h02. RSH by 9 -> 8'h00. ASR 8'h80 by 3 -> 8'hF0.
//    ASR 8'h80 by 12 -> 8'hFF.
//  - Backpressure: OutReady=0 for 5 cycles after an ADD result -> Out stable, InReady=0.
//    Then OutReady=1 with InValid=1 streaming 4 ADDs -> one result per cycle, in order.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - opcode mnemonics, FSM states and shared helpers for alu_mc
package definitions;

  typedef enum logic [3:0] {
    ADD  = 4'h0,
    SUB  = 4'h1,
    AND  = 4'h2,
    OR   = 4'h3,
    XOR  = 4'h4,
    LSH  = 4'h5,
    RSH  = 4'h6,
    MOV  = 4'h7,
    RXOR = 4'h8,
    BEQ  = 4'h9,
    BNE  = 4'hA,
    BGE  = 4'hB,
    MUL  = 4'hC,
    ASR  = 4'hD
  } op_mne;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic branch;
  } alu_flags_t;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == BEQ) || (op == BNE) || (op == BGE);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - radix-2 shift-add multiplier, W steps per product
module alu_mul_iter #(
  parameter int W = 8
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           start,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  a_q, hi, lo;
  logic [W-1:0]  a_sel, hi_sel, lo_sel;
  logic [W:0]    sum;
  logic [CW-1:0] rem;
  logic          done_q;

  // The first step runs on the start edge itself, so W-1 steps remain afterwards
  always_comb begin
    a_sel  = start ? A : a_q;
    hi_sel = start ? '0 : hi;
    lo_sel = start ? B : lo;
    sum    = {1'b0, hi_sel} + ({1'b0, a_sel} & {(W+1){lo_sel[0]}});
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_q    <= '0;
      hi     <= '0;
      lo     <= '0;
      rem    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        a_q      <= A;
        {hi, lo} <= {sum, lo_sel[W-1:1]};
        rem      <= CW'(W - 1);
      end else if (rem != '0) begin
        {hi, lo} <= {sum, lo_sel[W-1:1]};
        rem      <= rem - 1'b1;
        done_q   <= (rem == CW'(1));
      end
    end
  end

  assign busy = (rem != '0);
  assign done = done_q;
  assign prod = {hi, lo};

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake and registered result/flags
module alu_mc
  import definitions::*;
#(
  parameter int W   = 8,
  parameter int Ops = 4
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           InValid,
  output logic           InReady,
  input  logic [W-1:0]   InputA,
  input  logic [W-1:0]   InputB,
  input  logic [Ops-1:0] OP,
  output logic           OutValid,
  input  logic           OutReady,
  output logic [W-1:0]   Out,
  output logic [W-1:0]   OutHi,
  output logic           Zero,
  output logic           Negative,
  output logic           Carry,
  output logic           BranchFlag
);

  localparam logic [W-1:0] W_VAL = W'(W);

  alu_state_t     state, state_n;
  logic [3:0]     op;
  logic           accept, start_mul, load_alu, load_mul;
  logic           mul_busy, mul_done;
  logic [2*W-1:0] mul_prod;
  logic [W:0]     add_w, sub_w;
  logic           ovf, eq, ge, sh_over;
  logic [W-1:0]   res;
  alu_flags_t     flg;

  assign op = 4'(OP);

  alu_mul_iter #(.W(W)) u_mul (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .start  (start_mul),
    .A      (InputA),
    .B      (InputB),
    .busy   (mul_busy),
    .done   (mul_done),
    .prod   (mul_prod)
  );

  assign add_w   = {1'b0, InputA} + {1'b0, InputB};
  assign sub_w   = {1'b0, InputA} + {1'b0, ~InputB} + {{W{1'b0}}, 1'b1};
  assign ovf     = (InputA[W-1] != InputB[W-1]) && (sub_w[W-1] != InputA[W-1]);
  assign eq      = (InputA == InputB);
  assign ge      = ~(sub_w[W-1] ^ ovf);
  assign sh_over = (InputB >= W_VAL);

  // Single-cycle datapath; MUL and undefined opcodes fall through to a zero result
  always_comb begin
    res       = '0;
    flg.carry = 1'b0;
    case (op)
      ADD:                begin res = add_w[W-1:0]; flg.carry = add_w[W]; end
      SUB, BEQ, BNE, BGE: begin res = sub_w[W-1:0]; flg.carry = sub_w[W]; end
      AND:  res = InputA & InputB;
      OR:   res = InputA | InputB;
      XOR:  res = InputA ^ InputB;
      MOV:  res = InputB;
      LSH:  res = sh_over ? '0 : (InputA << InputB);
      RSH:  res = sh_over ? '0 : (InputA >> InputB);
      ASR:  res = sh_over ? {W{InputA[W-1]}} : W'($signed(InputA) >>> InputB);
      RXOR: res = {{(W-1){1'b0}}, ^InputA[W-2:0]};
      default: res = '0;
    endcase
    flg.zero     = (res == '0);
    flg.negative = res[W-1];
    flg.branch   = 1'b0;
    if (is_branch(op))
      flg.branch = (op == BEQ) ? eq : (op == BNE) ? ~eq : ge;
  end

  always_comb begin
    state_n = state;
    InReady = 1'b0;
    case (state)
      IDLE:    InReady = 1'b1;
      DONE:    InReady = OutReady;
      default: InReady = 1'b0;
    endcase
    accept = InValid & InReady;
    if (state == BUSY) begin
      if (mul_done && !mul_busy) state_n = DONE;
    end else if (accept) begin
      state_n = (op == MUL) ? BUSY : DONE;
    end else if (state == DONE && OutReady) begin
      state_n = IDLE;
    end
    start_mul = accept && (op == MUL);
    load_alu  = accept && (op != MUL);
    load_mul  = (state == BUSY) && mul_done;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      Out        <= '0;
      OutHi      <= '0;
      Zero       <= 1'b0;
      Negative   <= 1'b0;
      Carry      <= 1'b0;
      BranchFlag <= 1'b0;
    end else begin
      state <= state_n;
      if (load_alu) begin
        Out        <= res;
        OutHi      <= '0;
        Zero       <= flg.zero;
        Negative   <= flg.negative;
        Carry      <= flg.carry;
        BranchFlag <= flg.branch;
      end else if (load_mul) begin
        {OutHi, Out} <= mul_prod;
        Zero         <= (mul_prod == '0);
        Negative     <= mul_prod[2*W-1];
        Carry        <= 1'b0;
        BranchFlag   <= 1'b0;
      end
    end
  end

  assign OutValid = (state == DONE);

endmodule
